inst_fetch_resp: RTL and testbench

Instruction-fetch responder for the pipelined MIPS core. It is the memory-side end of the fetch interface: it accepts the fetch address and chip-enable from the PC generator and runs one request/grant/response transaction on the instruction-memory port. It returns the instruction word with a valid flag to the IF/ID stage, and raises a stall request back to the pipeline controller while a fetch is outstanding. It also handles pipeline flush (exception redirect), misaligned-PC detection and memory-timeout detection.

---
 rtl/inst_fetch_resp_pkg.sv | 30 +++
 rtl/inst_fetch_resp_if.sv | 39 +++
 rtl/inst_fetch_resp_timer.sv | 44 ++++
 rtl/inst_fetch_resp.sv | 125 ++++++++++++
 tb/tb_inst_fetch_resp.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp_pkg
// Shared types and constants for the instruction-fetch responder:
//   - fetch FSM state encoding (FetchIdle .. FetchDrop)
//   - bus widths (InstAddrBus, InstBus, word-address width)
//   - timeout counter width
//   - helper that flags a misaligned fetch address
// -----------------------------------------------------------------------------
package inst_fetch_resp_pkg;

  localparam int InstAddrBus   = 32;
  localparam int InstBus       = 32;
  localparam int WordAddrW     = 30;
  localparam int FetchTimeoutW = 8;
  localparam logic ChipEnable  = 1'b1;

  typedef enum logic [2:0] {
    FetchIdle = 3'd0,
    FetchReq  = 3'd1,
    FetchWait = 3'd2,
    FetchHold = 3'd3,
    FetchDrop = 3'd4
  } fetch_state_e;

  // Instructions are word aligned; any set low bit is an address error.
  function automatic logic pc_misaligned(input logic [InstAddrBus-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp_if
// Bundles the fetch-side and memory-side signals of the fetch responder.
//   Pipeline side : ce, pc, flush, stall_id -> inst, inst_valid, fetch_adel,
//                   fetch_berr, stallreq
//   Memory side   : mem_req, mem_addr -> mem_gnt, mem_rvalid, mem_rdata
// Modports:
//   slave  - the responder itself
//   master - the environment (PC generator, controller and memory)
// -----------------------------------------------------------------------------
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic                   ce;
  logic [InstAddrBus-1:0] pc;
  logic                   flush;
  logic                   stall_id;
  logic [InstBus-1:0]     inst;
  logic                   inst_valid;
  logic                   fetch_adel;
  logic                   fetch_berr;
  logic                   stallreq;
  logic                   mem_req;
  logic [WordAddrW-1:0]   mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [InstBus-1:0]     mem_rdata;

  modport slave (
    input  ce, pc, flush, stall_id, mem_gnt, mem_rvalid, mem_rdata,
    output inst, inst_valid, fetch_adel, fetch_berr, stallreq, mem_req, mem_addr
  );

  modport master (
    output ce, pc, flush, stall_id, mem_gnt, mem_rvalid, mem_rdata,
    input  inst, inst_valid, fetch_adel, fetch_berr, stallreq, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_fetch_resp_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Counts cycles spent waiting for a memory response.
//   clk       - core clock
//   rst       - asynchronous active-low reset
//   i_clear   - restart the count (a grant begins a new transaction)
//   i_enable  - count this cycle (waiting for a response)
//   o_expired - this enabled cycle is the TIMEOUT-th counted cycle (or later)
// -----------------------------------------------------------------------------
module fetch_timer
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // r_count holds the number of earlier counted cycles, so the last allowed
  // cycle sees TIMEOUT-1.
  localparam logic [FetchTimeoutW-1:0] Limit = FetchTimeoutW'(TIMEOUT - 32'd1);

  logic [FetchTimeoutW-1:0] r_count;

  // Saturating wait-cycle counter, cleared at the start of each transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // >= rather than == so a flush landing on the expiry cycle still times out in DROP
  assign o_expired = i_enable && (r_count >= Limit);

endmodule

// File: rtl/inst_fetch_resp.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp
// Memory-side end of the instruction-fetch path. Takes pc/ce from the PC
// generator, runs a single request/grant/response transaction on the
// instruction memory and returns the word with a valid flag to IF/ID.
// Handles flush, misaligned pc (fetch_adel) and memory timeout (fetch_berr).
//   clk - core clock
//   rst - asynchronous active-low reset
//   bus - inst_fetch_resp_if.slave (pipeline and memory signals)
// Parameter TIMEOUT (1..255): counted WAIT cycles before a bus error.
// -----------------------------------------------------------------------------
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_resp_if.slave  bus
);

  fetch_state_e         r_state;
  logic [InstBus-1:0]   r_inst;
  logic                 r_inst_valid;
  logic                 r_adel;
  logic                 r_berr;
  logic                 r_mem_req;
  logic [WordAddrW-1:0] r_mem_addr;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;

  // The count restarts on every grant, including a grant that is then dropped
  assign w_timer_clr = (r_state == FetchReq) && bus.mem_gnt;
  assign w_timer_en  = (r_state == FetchWait) || (r_state == FetchDrop);

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FetchIdle;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_adel       <= 1'b0;
      r_berr       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 30'd0;
    end else begin
      // Error flags and inst_valid are single-cycle pulses unless HOLD keeps valid.
      r_adel       <= 1'b0;
      r_berr       <= 1'b0;
      r_inst_valid <= 1'b0;
      case (r_state)
        FetchIdle: begin
          if ((bus.ce == ChipEnable) && !bus.flush) begin
            if (pc_misaligned(bus.pc)) begin
              r_adel <= 1'b1;
            end else begin
              r_mem_addr <= bus.pc[31:2];
              r_mem_req  <= 1'b1;
              r_state    <= FetchReq;
            end
          end
        end
        FetchReq: begin
          if (bus.flush) begin
            // A grant in the flush cycle leaves a response in flight to drain.
            r_mem_req <= 1'b0;
            r_state   <= bus.mem_gnt ? FetchDrop : FetchIdle;
          end else if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= FetchWait;
          end
        end
        FetchWait: begin
          if (bus.flush) begin
            r_state <= bus.mem_rvalid ? FetchIdle : FetchDrop;
          end else if (bus.mem_rvalid) begin
            r_inst       <= bus.mem_rdata;
            r_inst_valid <= 1'b1;
            r_state      <= bus.stall_id ? FetchHold : FetchIdle;
          end else if (w_expired) begin
            r_berr  <= 1'b1;
            r_state <= FetchIdle;
          end
        end
        FetchHold: begin
          if (bus.flush || !bus.stall_id) begin
            r_state <= FetchIdle;
          end else begin
            r_inst_valid <= r_inst_valid;
          end
        end
        FetchDrop: begin
          if (bus.mem_rvalid || w_expired) begin
            r_state <= FetchIdle;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= FetchIdle;
        end
      endcase
    end
  end

  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_inst_valid;
  assign bus.fetch_adel = r_adel;
  assign bus.fetch_berr = r_berr;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.stallreq   = (r_state != FetchIdle);

endmodule

// File: tb/tb_inst_fetch_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_resp
// Directed self-checking bench for inst_fetch_resp (TIMEOUT = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_resp;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_fetch_resp_if bus ();

  inst_fetch_resp #(
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b0;
    bus.ce         = 1'b0;
    bus.pc         = 32'd0;
    bus.flush      = 1'b0;
    bus.stall_id   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;

    // Reset state
    #3;
    check("rst_inst",     bus.inst,                32'd0);
    check("rst_valid",    {31'd0, bus.inst_valid}, 32'd0);
    check("rst_adel",     {31'd0, bus.fetch_adel}, 32'd0);
    check("rst_berr",     {31'd0, bus.fetch_berr}, 32'd0);
    check("rst_memreq",   {31'd0, bus.mem_req},    32'd0);
    check("rst_memaddr",  {2'd0, bus.mem_addr},    32'd0);
    check("rst_stallreq", {31'd0, bus.stallreq},   32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Best-case fetch at the boot vector
    bus.ce = 1'b1; bus.pc = 32'hBFC00000;
    check("t0_stallreq", {31'd0, bus.stallreq}, 32'd0);
    tick();
    bus.ce = 1'b0;
    check("t1_memreq",   {31'd0, bus.mem_req},    32'd1);
    check("t1_memaddr",  {2'd0, bus.mem_addr},    32'h2FF00000);
    check("t1_stallreq", {31'd0, bus.stallreq},   32'd1);
    check("t1_valid",    {31'd0, bus.inst_valid}, 32'd0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("t2_stallreq", {31'd0, bus.stallreq}, 32'd1);
    check("t2_memreq",   {31'd0, bus.mem_req},  32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3C1D8000;
    tick();
    bus.mem_rvalid = 1'b0;
    check("t3_valid",    {31'd0, bus.inst_valid}, 32'd1);
    check("t3_inst",     bus.inst,                32'h3C1D8000);
    check("t3_stallreq", {31'd0, bus.stallreq},   32'd0);
    tick();
    check("t4_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("t4_inst",  bus.inst,                32'h3C1D8000);

    // Misaligned pc
    bus.ce = 1'b1; bus.pc = 32'h00000402;
    tick();
    bus.ce = 1'b0;
    check("adel_pulse",    {31'd0, bus.fetch_adel}, 32'd1);
    check("adel_memreq",   {31'd0, bus.mem_req},    32'd0);
    check("adel_valid",    {31'd0, bus.inst_valid}, 32'd0);
    check("adel_stallreq", {31'd0, bus.stallreq},   32'd0);
    tick();
    check("adel_end",     {31'd0, bus.fetch_adel}, 32'd0);
    check("adel_memreq2", {31'd0, bus.mem_req},    32'd0);

    // Downstream stall holds the instruction for 4 cycles
    bus.ce = 1'b1; bus.pc = 32'h00000100;
    tick();
    bus.ce = 1'b0;
    check("hold_memaddr", {2'd0, bus.mem_addr}, 32'h00000040);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h24020001; bus.stall_id = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hold_inst",  bus.inst,                32'h24020001);
      check("hold_stall", {31'd0, bus.stallreq},   32'd1);
      tick();
    end
    check("hold_valid4", {31'd0, bus.inst_valid}, 32'd1);
    check("hold_inst4",  bus.inst,                32'h24020001);
    bus.stall_id = 1'b0;
    tick();
    check("hold_rel_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("hold_rel_stall", {31'd0, bus.stallreq},   32'd0);

    // Flush in WAIT, late response is dropped
    bus.ce = 1'b1; bus.pc = 32'h00000200;
    tick();
    bus.ce = 1'b0; bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drop_stall1", {31'd0, bus.stallreq},   32'd1);
    check("drop_valid1", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    check("drop_stall2", {31'd0, bus.stallreq}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    check("drop_idle",  {31'd0, bus.stallreq},   32'd0);
    check("drop_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("drop_inst",  bus.inst,                32'h24020001);

    // Next fetch after the flush completes normally
    bus.ce = 1'b1; bus.pc = 32'h00000300;
    tick();
    bus.ce = 1'b0;
    check("refetch_addr", {2'd0, bus.mem_addr}, 32'h000000C0);
    check("refetch_req",  {31'd0, bus.mem_req}, 32'd1);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAABBCCDD;
    tick();
    bus.mem_rvalid = 1'b0;
    check("refetch_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("refetch_inst",  bus.inst,                32'hAABBCCDD);
    tick();

    // Flush in REQ before grant withdraws the request
    bus.ce = 1'b1; bus.pc = 32'h00000600;
    tick();
    bus.ce = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("reqflush_memreq", {31'd0, bus.mem_req},  32'd0);
    check("reqflush_stall",  {31'd0, bus.stallreq}, 32'd0);

    // Timeout: grant but no response
    bus.ce = 1'b1; bus.pc = 32'h00000400;
    tick();
    bus.ce = 1'b0; bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_berr_low", {31'd0, bus.fetch_berr}, 32'd0);
      check("to_stall",    {31'd0, bus.stallreq},   32'd1);
      tick();
    end
    check("to_berr",  {31'd0, bus.fetch_berr}, 32'd1);
    check("to_idle",  {31'd0, bus.stallreq},   32'd0);
    check("to_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    check("to_berr_end", {31'd0, bus.fetch_berr}, 32'd0);

    // Reset in WAIT, then a late response is ignored
    bus.ce = 1'b1; bus.pc = 32'h00000500;
    tick();
    bus.ce = 1'b0; bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("prerst_stall", {31'd0, bus.stallreq}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall",   {31'd0, bus.stallreq},   32'd0);
    check("arst_inst",    bus.inst,                32'd0);
    check("arst_memaddr", {2'd0, bus.mem_addr},    32'd0);
    check("arst_memreq",  {31'd0, bus.mem_req},    32'd0);
    check("arst_valid",   {31'd0, bus.inst_valid}, 32'd0);
    tick();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_rvalid = 1'b0;
    check("late_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("late_stall", {31'd0, bus.stallreq},   32'd0);
    check("late_inst",  bus.inst,                32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
